hyperbus_read_ctrl: RTL
=======================

HYPERBUS_READ_CTRL -- requirements
Module: hyperbus_read_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- LEN_W  16  width of the burst-length field, in 16-bit words minus one.
- TO_W  16  width of the inter-word timeout counter.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk0  in  1  single clock for the whole block.
- rst_i  in  1  reset; synchronous, active-high.
- cfg_latency_i  in  8  clk0 cycles from request accept to read_clk_en_o high.
- cfg_timeout_i  in  TO_W  max clk0 cycles between accepted words; 0 disables.
- cfg_drain_i  in  4  settle cycles after the read-clock gate closes.
- req_valid_i  in  1  read-burst request.
- req_ready_o  out  1  request accepted when both are high.
- req_len_i  in  LEN_W  burst words minus one.
- read_clk_en_o  out  1  gates the RWDS read clock.
- en_ddr_in_o  out  1  DDR input enable.
- fifo_valid_i  in  1  CDC FIFO word available.
- fifo_data_i  in  16  CDC FIFO word.
- fifo_ready_o  out  1  pops the CDC FIFO.
- rx_valid_o  out  1  word to the consumer.
- rx_data_o  out  16  word to the consumer.
- rx_last_o  out  1  final word of the burst.
- rx_ready_i  in  1  consumer accepts the word.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle burst-complete pulse.
- err_o  out  1  qualifies done_o; high means the burst timed out.

Function
REQ-003 The FSM SHALL have the states IDLE, WAIT_LAT, RECEIVE, DRAIN and DONE.
REQ-004 The block SHALL drive req_ready_o high only in IDLE.
- On an accepted request it latches req_len_i into a remaining-word counter, loads the latency counter with cfg_latency_i, and moves to WAIT_LAT.
REQ-005 WAIT_LAT SHALL behave as follows.
- en_ddr_in_o is high and read_clk_en_o is low.
- The latency counter decrements each cycle.
- The FSM moves to RECEIVE in the cycle after the counter reads 0.
- cfg_latency_i = 0 therefore gives exactly 1 cycle in WAIT_LAT.
REQ-006 RECEIVE SHALL behave as follows.
- read_clk_en_o and en_ddr_in_o are high.
- rx_valid_o = fifo_valid_i, rx_data_o = fifo_data_i, and fifo_ready_o = rx_ready_i, all combinational with zero latency.
REQ-007 rx_last_o SHALL equal (remaining counter == 0) AND rx_valid_o.
REQ-008 Each rx handshake SHALL decrement the remaining counter.
- The handshake on the last word moves the FSM to DRAIN with err cleared.
- A length of 2^LEN_W words is supported with no wrap-around.
REQ-009 Timeout counter (TO_W bits) SHALL follow these rules.
- It clears on entry to RECEIVE and on every rx handshake.
- It increments otherwise, saturating at all-ones.
- When cfg_timeout_i != 0 and the counter equals cfg_timeout_i, the FSM moves to DRAIN with err set.
REQ-010 If the last-word handshake and timeout expiry coincide, the handshake SHALL win and err stays clear.
REQ-011 DRAIN SHALL behave as follows.
- read_clk_en_o and en_ddr_in_o are low.
- fifo_ready_o is high and rx_valid_o is low, so stray FIFO words are silently discarded.
- The FSM stays in DRAIN for exactly cfg_drain_i+1 cycles, then moves to DONE.
REQ-012 DONE SHALL last one cycle.
- done_o is high and err_o equals the latched err flag.
- The FSM returns to IDLE.
- err_o is low whenever done_o is low.
REQ-013 Outside RECEIVE, rx_valid_o SHALL be 0, and fifo_ready_o SHALL be 0 except in DRAIN.
REQ-014 cfg_* inputs SHALL be sampled only at the point of use: cfg_latency_i at accept, cfg_timeout_i each RECEIVE cycle, cfg_drain_i on DRAIN entry.

Reset
REQ-015 With rst_i high at a clk0 edge, the FSM SHALL go to IDLE and all counters and the err flag SHALL clear, including mid-burst.
REQ-016 Output values after reset SHALL be:
- req_ready_o = 1.
- read_clk_en_o, en_ddr_in_o, fifo_ready_o, rx_valid_o, rx_last_o, busy_o, done_o and err_o = 0.
- rx_data_o = fifo_data_i.
REQ-017 A reset taken during RECEIVE SHALL drop read_clk_en_o in the same cycle rst_i is sampled, with no DONE pulse.

Structure
REQ-018 The state enum, the LEN_W/TO_W defaults and a cfg struct (latency, timeout, drain) SHALL live in the shared hyperbus_pkg.
REQ-019 The block SHALL be a single module with no sub-modules; the counters are inline.

Verification
REQ-020 Directed scenarios the bench SHALL cover:
- Nominal burst: len=3, latency=4, drain=2, FIFO always valid, rx_ready_i=1 -> read_clk_en_o rises 5 cycles after accept; 4 words pass; rx_last_o on word 4; done_o 3 cycles later with err_o=0.
- Backpressure: len=1, rx_ready_i toggling 0/1 -> fifo_ready_o mirrors rx_ready_i; exactly 2 pops; no word lost or duplicated.
- Timeout: timeout=10, FIFO never valid -> DRAIN entered 10 cycles into RECEIVE; done_o with err_o=1; no rx_valid_o.
- Coincidence: last handshake in the same cycle the counter hits cfg_timeout_i -> err_o=0.
- Stray words: 3 extra FIFO words during DRAIN -> all popped; rx_valid_o stays 0.
- Mid-burst reset: rst_i asserted during RECEIVE -> next cycle IDLE; read_clk_en_o=0; no done_o; a new request is accepted normally.

Source files
------------

// File: rtl/hyperbus_pkg.sv
// Shared types and defaults for the HyperBus read path.
// Holds the controller state encoding and the run-time configuration bundle.
package hyperbus_pkg;

  localparam int LEN_W_DEF = 16;
  localparam int TO_W_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LAT,
    RECEIVE,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [7:0]          latency;
    logic [TO_W_DEF-1:0] timeout;
    logic [3:0]          drain;
  } cfg_t;

endpackage

// File: rtl/hyperbus_read_ctrl.sv
// HyperBus read-burst controller: waits out the initial latency, forwards CDC FIFO
// words to the consumer, guards against a stalled device with a timeout, then drains.
module hyperbus_read_ctrl
  import hyperbus_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int TO_W  = TO_W_DEF
) (
  input  logic             clk0,
  input  logic             rst_i,
  input  logic [7:0]       cfg_latency_i,
  input  logic [TO_W-1:0]  cfg_timeout_i,
  input  logic [3:0]       cfg_drain_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [LEN_W-1:0] req_len_i,
  output logic             read_clk_en_o,
  output logic             en_ddr_in_o,
  input  logic             fifo_valid_i,
  input  logic [15:0]      fifo_data_i,
  output logic             fifo_ready_o,
  output logic             rx_valid_o,
  output logic [15:0]      rx_data_o,
  output logic             rx_last_o,
  input  logic             rx_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] rem_cnt;
  logic [7:0]       lat_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [3:0]       drain_cnt;
  logic             err_q;

  logic accept;
  logic hs;
  logic last_hs;
  logic timeout_hit;

  // rem_cnt holds words-minus-one, so the final word is seen at zero and a
  // full 2^LEN_W burst never needs the counter to wrap.
  assign accept      = req_valid_i && (state == IDLE);
  assign hs          = (state == RECEIVE) && fifo_valid_i && rx_ready_i;
  assign last_hs     = hs && (rem_cnt == '0);
  assign timeout_hit = (state == RECEIVE) && (cfg_timeout_i != '0) && (to_cnt == cfg_timeout_i);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = WAIT_LAT;
      WAIT_LAT: if (lat_cnt == 8'd0) state_nxt = RECEIVE;
      RECEIVE:  if (last_hs || timeout_hit) state_nxt = DRAIN;
      DRAIN:    if (drain_cnt == 4'd0) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk0) begin
    if (rst_i) begin
      state     <= IDLE;
      rem_cnt   <= '0;
      lat_cnt   <= '0;
      to_cnt    <= '0;
      drain_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            rem_cnt <= req_len_i;
            lat_cnt <= cfg_latency_i;
            err_q   <= 1'b0;
          end
        end
        WAIT_LAT: begin
          if (lat_cnt != 8'd0) lat_cnt <= lat_cnt - 8'd1;
          else                 to_cnt  <= '0;
        end
        RECEIVE: begin
          if (hs) begin
            to_cnt <= '0;
            if (!last_hs) rem_cnt <= rem_cnt - LEN_W'(1);
          end else if (to_cnt != '1) begin
            to_cnt <= to_cnt + TO_W'(1);
          end
          // A final handshake outranks a simultaneous timeout.
          if (last_hs || timeout_hit) begin
            drain_cnt <= cfg_drain_i;
            err_q     <= !last_hs;
          end
        end
        DRAIN: begin
          if (drain_cnt != 4'd0) drain_cnt <= drain_cnt - 4'd1;
        end
        DONE: err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // The read clock is also gated by rst_i so a mid-burst reset stops RWDS at once.
  always_comb begin
    req_ready_o   = 1'b0;
    read_clk_en_o = 1'b0;
    en_ddr_in_o   = 1'b0;
    fifo_ready_o  = 1'b0;
    rx_valid_o    = 1'b0;
    done_o        = 1'b0;
    err_o         = 1'b0;
    case (state)
      IDLE:     req_ready_o = 1'b1;
      WAIT_LAT: en_ddr_in_o = 1'b1;
      RECEIVE: begin
        read_clk_en_o = !rst_i;
        en_ddr_in_o   = 1'b1;
        rx_valid_o    = fifo_valid_i;
        fifo_ready_o  = rx_ready_i;
      end
      DRAIN:    fifo_ready_o = 1'b1;
      DONE: begin
        done_o = 1'b1;
        err_o  = err_q;
      end
      default: ;
    endcase
    rx_last_o = rx_valid_o && (rem_cnt == '0);
  end

  assign rx_data_o = fifo_data_i;
  assign busy_o    = (state != IDLE);

endmodule
